// File: rtl/deser_stream_pkg.sv
// Shared types and elaboration helpers for the deser_stream packer.
package deser_stream_pkg;

  typedef enum logic {
    ST_FILL,
    ST_PEND
  } deser_state_e;

  function automatic int beats(input int data_o_w, input int data_i_w);
    return data_o_w / data_i_w;
  endfunction

  function automatic int cnt_w(input int n_beats);
    return $clog2(n_beats + 1);
  endfunction

  // A beat must tile the word exactly and a word needs at least two beats.
  function automatic bit widths_ok(input int data_o_w, input int data_i_w);
    return (data_i_w > 0) && (data_o_w % data_i_w == 0) && (data_o_w / data_i_w >= 2);
  endfunction

endpackage

// File: rtl/deser_stream_out_reg.sv
// One-deep output word register with valid/ready toward the sink.
module deser_stream_out_reg #(
  parameter int DATA_O_W = 16,
  parameter int CNT_W    = 5
) (
  input  logic                clk_i,
  input  logic                srst_n_i,
  input  logic                load,
  input  logic [DATA_O_W-1:0] load_data,
  input  logic [CNT_W-1:0]    load_cnt,
  output logic                full,
  output logic                drain,
  output logic [DATA_O_W-1:0] deser_data_o,
  output logic [CNT_W-1:0]    deser_cnt_o,
  output logic                deser_data_val_o,
  input  logic                deser_data_rdy_i
);

  assign full  = deser_data_val_o;
  assign drain = deser_data_val_o && deser_data_rdy_i;

  // NOTE: state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      deser_data_o     <= '0;
      deser_cnt_o      <= '0;
      deser_data_val_o <= 1'b0;
    end else if (load) begin
      deser_data_o     <= load_data;
      deser_cnt_o      <= load_cnt;
      deser_data_val_o <= 1'b1;
    end else if (drain) begin
      deser_data_val_o <= 1'b0;
    end
  end

endmodule

// File: rtl/deser_stream.sv
// deser_stream: ready/valid serial-to-parallel packer, first beat lands in the MSBs.
// Define DESER_STREAM_FLUSH_EN to let data_last_i close a partial word early.
module deser_stream
  import deser_stream_pkg::*;
#(
  parameter int  DATA_I_W = 1,
  parameter int  DATA_O_W = 16,
  localparam int BEATS    = beats(DATA_O_W, DATA_I_W),
  localparam int CNT_W    = cnt_w(BEATS)
) (
  input  logic                clk_i,
  input  logic                srst_n_i,
  input  logic [DATA_I_W-1:0] data_i,
  input  logic                data_val_i,
  input  logic                data_last_i,
  output logic                data_rdy_o,
  output logic [DATA_O_W-1:0] deser_data_o,
  output logic [CNT_W-1:0]    deser_cnt_o,
  output logic                deser_data_val_o,
  input  logic                deser_data_rdy_i
);

  if (!widths_ok(DATA_O_W, DATA_I_W)) begin : g_bad_widths
    $error("deser_stream: DATA_I_W must divide DATA_O_W into at least two beats");
  end

  deser_state_e        state_q, state_d;
  logic [DATA_O_W-1:0] acc_q, acc_d, word, load_data;
  logic [CNT_W-1:0]    cnt_q, cnt_d, done_cnt, load_cnt;
  logic                accept, word_done, flush_hit;
  logic                load, out_full, out_drain, out_free;

  assign data_rdy_o = srst_n_i && (state_q == ST_FILL);
  assign accept     = data_val_i && data_rdy_o;
  assign out_free   = !out_full || out_drain;
  assign word_done  = (cnt_q == CNT_W'(BEATS - 1)) || flush_hit;

`ifdef DESER_STREAM_FLUSH_EN
  assign flush_hit = data_last_i;
  assign done_cnt  = cnt_q + CNT_W'(1);
`else
  logic unused_last;
  assign unused_last = data_last_i;
  assign flush_hit   = 1'b0;
  assign done_cnt    = CNT_W'(BEATS);
`endif

  // While a word is pending, cnt_q holds its beat count rather than a write index.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    word = acc_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CNT_W'(k)) word[DATA_O_W-1-k*DATA_I_W -: DATA_I_W] = data_i;
    end

    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_data = word;
    load_cnt  = done_cnt;

    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (!word_done) begin
            acc_d = word;
            cnt_d = cnt_q + CNT_W'(1);
          end else if (out_free) begin
            load  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            state_d = ST_PEND;
            acc_d   = word;
            cnt_d   = done_cnt;
          end
        end
      end
      ST_PEND: begin
        load_data = acc_q;
        load_cnt  = cnt_q;
        if (out_free) begin
          load    = 1'b1;
          state_d = ST_FILL;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= ST_FILL;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  deser_stream_out_reg #(
    .DATA_O_W(DATA_O_W),
    .CNT_W   (CNT_W)
  ) u_out_reg (
    .clk_i           (clk_i),
    .srst_n_i        (srst_n_i),
    .load            (load),
    .load_data       (load_data),
    .load_cnt        (load_cnt),
    .full            (out_full),
    .drain           (out_drain),
    .deser_data_o    (deser_data_o),
    .deser_cnt_o     (deser_cnt_o),
    .deser_data_val_o(deser_data_val_o),
    .deser_data_rdy_i(deser_data_rdy_i)
  );

endmodule

// File: tb/tb_deser_stream.sv
// Bench for deser_stream: a 1-bit and a 4-bit instance against a word-list model plus literal checks.
`timescale 1ns/1ps
module tb_deser_stream;

  localparam int W_O = 16;
`ifdef DESER_STREAM_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst_n;
  logic [0:0]  d1_data;
  logic        d1_val, d1_last, d1_rdy, s1_rdy, o1_val;
  logic [15:0] o1_data;
  logic [4:0]  o1_cnt;
  logic [3:0]  d4_data;
  logic        d4_val, d4_last, d4_rdy, s4_rdy, o4_val;
  logic [15:0] o4_data;
  logic [2:0]  o4_cnt;

  deser_stream #(.DATA_I_W(1), .DATA_O_W(16)) u_dut1 (
    .clk_i(clk), .srst_n_i(srst_n), .data_i(d1_data), .data_val_i(d1_val),
    .data_last_i(d1_last), .data_rdy_o(d1_rdy), .deser_data_o(o1_data),
    .deser_cnt_o(o1_cnt), .deser_data_val_o(o1_val), .deser_data_rdy_i(s1_rdy)
  );

  deser_stream #(.DATA_I_W(4), .DATA_O_W(16)) u_dut4 (
    .clk_i(clk), .srst_n_i(srst_n), .data_i(d4_data), .data_val_i(d4_val),
    .data_last_i(d4_last), .data_rdy_o(d4_rdy), .deser_data_o(o4_data),
    .deser_cnt_o(o4_cnt), .deser_data_val_o(o4_val), .deser_data_rdy_i(s4_rdy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc, stall_cnt;

  // Model: per instance, a partial word being built and a list of at most two finished words.
  int m_part[2], m_got[2], m_n[2];
  int m_fd[2][2], m_fc[2][2];
  bit m_rst;

  // Words actually handed to the sink, with the edge on which they left.
  int log_d[2][32], log_c[2][32], log_cyc[2][32], log_n[2];

  function automatic int iw(input int d);  return (d == 0) ? 1 : 4; endfunction
  function automatic bit sink(input int d);   return (d == 0) ? s1_rdy : s4_rdy; endfunction
  function automatic bit in_val(input int d); return (d == 0) ? d1_val : d4_val; endfunction
  function automatic bit in_last(input int d); return (d == 0) ? d1_last : d4_last; endfunction
  function automatic int in_data(input int d); return (d == 0) ? int'(d1_data) : int'(d4_data); endfunction
  function automatic bit dut_rdy(input int d); return (d == 0) ? d1_rdy : d4_rdy; endfunction
  function automatic bit dut_val(input int d); return (d == 0) ? o1_val : o4_val; endfunction
  function automatic int dut_data(input int d); return (d == 0) ? int'(o1_data) : int'(o4_data); endfunction
  function automatic int dut_cnt(input int d); return (d == 0) ? int'(o1_cnt) : int'(o4_cnt); endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit xfer, take;
    m_rst = !srst_n;
    for (int d = 0; d < 2; d++) begin
      if (!srst_n) begin
        m_part[d] = 0;
        m_got[d]  = 0;
        m_n[d]    = 0;
      end else begin
        xfer = (m_n[d] > 0) && sink(d);
        take = in_val(d) && (m_n[d] < 2);
        if (xfer) begin
          m_fd[d][0] = m_fd[d][1];
          m_fc[d][0] = m_fc[d][1];
          m_n[d]--;
        end
        if (take) begin
          m_part[d] = m_part[d] | (in_data(d) << (W_O - (m_got[d] + 1) * iw(d)));
          m_got[d]++;
          if (m_got[d] == W_O / iw(d) || (FLUSH && in_last(d))) begin
            m_fd[d][m_n[d]] = m_part[d];
            m_fc[d][m_n[d]] = m_got[d];
            m_n[d]++;
            m_part[d] = 0;
            m_got[d]  = 0;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rdy%0d", d), dut_rdy(d), srst_n && (m_n[d] < 2));
      check($sformatf("val%0d", d), dut_val(d), m_n[d] > 0);
      if (m_rst) begin
        check($sformatf("rst_data%0d", d), dut_data(d), 0);
        check($sformatf("rst_cnt%0d", d), dut_cnt(d), 0);
      end else if (m_n[d] > 0) begin
        check($sformatf("data%0d", d), dut_data(d), m_fd[d][0]);
        check($sformatf("cnt%0d", d), dut_cnt(d), m_fc[d][0]);
      end
      if (srst_n && dut_val(d) && sink(d) && log_n[d] < 32) begin
        log_d[d][log_n[d]]   = dut_data(d);
        log_c[d][log_n[d]]   = dut_cnt(d);
        log_cyc[d][log_n[d]] = cyc + 1;
        log_n[d]++;
      end
    end
  end

  task automatic set_in(input int d, input int data, input bit val, input bit last);
    if (d == 0) begin
      d1_data = data[0];
      d1_val  = val;
      d1_last = last;
    end else begin
      d4_data = data[3:0];
      d4_val  = val;
      d4_last = last;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d, input int data, input bit last);
    bit ok;
    set_in(d, data, 1'b1, last);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      ok = dut_rdy(d);
      @(posedge clk);
      #1;
      if (ok) begin
        acc_cyc = cyc;
        return;
      end
      stall_cnt++;
    end
    total++;
    bad++;
    $display("FAIL send%0d: beat not accepted within 300 cycles", d);
  endtask

  task automatic send_word1(input logic [15:0] w);
    for (int i = 0; i < 16; i++) send(0, int'(w[15-i]), 1'b0);
  endtask

  initial begin
    logic [15:0] w;
    int base, t_acc, stall0;
    int nib[8];

    srst_n = 1'b0;
    s1_rdy = 1'b1;
    s4_rdy = 1'b1;
    stall_cnt = 0;
    set_in(0, 0, 1'b0, 1'b0);
    set_in(1, 0, 1'b0, 1'b0);
    wait_cyc(3);
    srst_n = 1'b1;
    wait_cyc(1);

    // 1-bit beats, sink ready: one word, valid one edge after the last beat.
    base = log_n[0];
    send_word1(16'hA0F3);
    t_acc = acc_cyc;
    set_in(0, 0, 1'b0, 1'b0);
    wait_cyc(3);
    check("t1_data", log_d[0][base], 16'hA0F3);
    check("t1_cnt", log_c[0][base], 16);
    check("t1_latency", log_cyc[0][base] - t_acc, 1);

    // 4-bit beats back to back: two words on consecutive word slots, no stall.
    base = log_n[1];
    stall0 = stall_cnt;
    for (int i = 0; i < 8; i++) send(1, i + 1, 1'b0);
    set_in(1, 0, 1'b0, 1'b0);
    wait_cyc(3);
    check("t2_word0", log_d[1][base], 16'h1234);
    check("t2_word1", log_d[1][base+1], 16'h5678);
    check("t2_cnt1", log_c[1][base+1], 4);
    check("t2_slot", log_cyc[1][base+1] - log_cyc[1][base], 4);
    check("t2_stalls", stall_cnt - stall0, 0);

    // Sink stalled: first word held, second pending, input blocked after 32 beats.
    base = log_n[0];
    s1_rdy = 1'b0;
    send_word1(16'h1234);
    send_word1(16'hBEEF);
    w = 16'h0F0F;
    set_in(0, int'(w[15]), 1'b1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      check("t3_rdy_low", d1_rdy, 1'b0);
      check("t3_val", o1_val, 1'b1);
      check("t3_hold", o1_data, 16'h1234);
      @(posedge clk);
      #1;
    end
    s1_rdy = 1'b1;
    send_word1(16'h0F0F);
    set_in(0, 0, 1'b0, 1'b0);
    wait_cyc(4);
    check("t3_count", log_n[0] - base, 3);
    check("t3_word0", log_d[0][base], 16'h1234);
    check("t3_word1", log_d[0][base+1], 16'hBEEF);
    check("t3_word2", log_d[0][base+2], 16'h0F0F);

    // Flush stimulus on the 4-bit instance: A, B(last), C, D, E, F, 1, 2(last).
    base = log_n[1];
    nib = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2};
    for (int i = 0; i < 8; i++) send(1, nib[i], (i == 1) || (i == 7));
    set_in(1, 0, 1'b0, 1'b0);
    wait_cyc(4);
`ifdef DESER_STREAM_FLUSH_EN
    check("t4_count", log_n[1] - base, 3);
    check("t4_word0", log_d[1][base], 16'hAB00);
    check("t4_cnt0", log_c[1][base], 2);
    check("t4_word1", log_d[1][base+1], 16'hCDEF);
    check("t4_cnt1", log_c[1][base+1], 4);
    check("t4_word2", log_d[1][base+2], 16'h1200);
    check("t4_cnt2", log_c[1][base+2], 2);
`else
    check("t4_count", log_n[1] - base, 2);
    check("t4_word0", log_d[1][base], 16'hABCD);
    check("t4_cnt0", log_c[1][base], 4);
    check("t4_word1", log_d[1][base+1], 16'hEF12);
    check("t4_cnt1", log_c[1][base+1], 4);
`endif

    // Reset after 7 beats discards the partial word.
    base = log_n[0];
    w = 16'hFFFF;
    for (int i = 0; i < 7; i++) send(0, int'(w[15-i]), 1'b0);
    set_in(0, 0, 1'b0, 1'b0);
    srst_n = 1'b0;
    wait_cyc(1);
    @(negedge clk);
    check("t5_rst_rdy", d1_rdy, 1'b0);
    check("t5_rst_val", o1_val, 1'b0);
    check("t5_rst_data", o1_data, 16'h0000);
    check("t5_rst_cnt", o1_cnt, 5'd0);
    wait_cyc(2);
    srst_n = 1'b1;
    wait_cyc(1);
    send_word1(16'hC35A);
    set_in(0, 0, 1'b0, 1'b0);
    wait_cyc(4);
    check("t5_count", log_n[0] - base, 1);
    check("t5_word", log_d[0][base], 16'hC35A);
    check("t5_cnt", log_c[0][base], 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deser_stream.md
# deser_stream

Parametrised serial-to-parallel converter with a ready/valid handshake on both sides. It accepts `DATA_I_W`-bit beats and packs them MSB-first into `DATA_O_W`-bit words. An optional flush on `data_last_i` emits a partial word. It sits between a serial/narrow link receiver and wide-word consumers, and replaces the fixed 1-bit, no-backpressure deserializer in new designs.

## Interface
- `DATA_I_W`, default 1: input beat width; must divide `DATA_O_W`.
- `DATA_O_W`, default 16: output word width.
- `BEATS` (localparam) = `DATA_O_W / DATA_I_W`, must be ≥ 2.
- `CNT_W` (localparam) = `$clog2(BEATS+1)`.
- `clk_i` in, 1: single clock, all logic on rising edge.
- `srst_n_i` in, 1: reset, synchronous, active-low.
- `data_i` in, `DATA_I_W`: input beat.
- `data_val_i` in, 1: beat valid.
- `data_last_i` in, 1: beat is last of packet; sampled with `data_val_i`.
- `data_rdy_o` out, 1: block can accept a beat.
- `deser_data_o` out, `DATA_O_W`: assembled word.
- `deser_cnt_o` out, `CNT_W`: valid beats in `deser_data_o` (1..`BEATS`).
- `deser_data_val_o` out, 1: word valid.
- `deser_data_rdy_i` in, 1: sink accepts word.

## Operation
- Input beat accepted iff `data_val_i && data_rdy_o`. Output word transferred iff `deser_data_val_o && deser_data_rdy_i`.
- Accumulator: `acc` (`DATA_O_W`) plus beat counter `cnt` (0..`BEATS-1`). Accepted beat k is written to `acc[DATA_O_W-1-k*DATA_I_W -: DATA_I_W]`, so the first beat lands in the MSBs.
- Word completes on an accepted beat when `cnt == BEATS-1`, or when `data_last_i` is high (flush builds only).
- On completion the word moves to the output register if the register is empty or drained in the same cycle. Otherwise the word is held in `acc`, flag `pend` is set, and no further beats are accepted.
- On a flush, unwritten low bits of the word are 0, and `deser_cnt_o` = k+1.
- After completion `cnt` returns to 0 and `acc` clears. A beat accepted in the same cycle as the word's exit starts a fresh word.
- `data_rdy_o` = `srst_n_i && !pend`, combinational from state.
- When `pend` is set and the output drains, the pending word moves to the output register in that cycle. `pend` clears and `data_rdy_o` rises the next cycle.
- `data_last_i` on a full `BEATS`-th beat behaves as a normal completion with count `BEATS`.
- `data_i` and `data_last_i` are don't-care when the beat is not accepted.

## Timing
- Reset (`srst_n_i`=0 at clock edge):
  - `deser_data_o`=0, `deser_cnt_o`=0, `deser_data_val_o`=0.
  - `cnt`=0, `acc`=0, `pend`=0.
  - `data_rdy_o`=0 while reset is held.
  - A partial word in progress is discarded with no output.
- Latency: the word is valid in the cycle after its final beat is accepted, provided the output register is free.
- Throughput: one beat per cycle sustained while `deser_data_rdy_i` stays high. No bubble between words.
- Backpressure: while `deser_data_val_o`=1 and `deser_data_rdy_i`=0, `deser_data_o` and `deser_cnt_o` are stable. The block absorbs at most one more complete word, then drops `data_rdy_o`.
- `deser_data_val_o` falls the cycle after a transfer unless a new word is loaded in that same cycle.

## Configuration
- `DESER_STREAM_FLUSH_EN` defined: `data_last_i` forces completion of a partial word as described above.
- Not defined:
  - `data_last_i` is ignored.
  - Words complete only after `BEATS` beats.
  - `deser_cnt_o` is tied to `BEATS`.
  - The flush compare logic is absent.

## Structure
- Package `deser_stream_pkg` holds:
  - function `beats(DATA_O_W, DATA_I_W)`;
  - `cnt_w` helper;
  - elaboration-time check that `DATA_I_W` divides `DATA_O_W`.
- Sub-module `deser_stream_out_reg`:
  - one-deep output register with valid/ready;
  - `load`/`full`/`drain` signals to the accumulator logic.
- The top level holds the accumulator, counter, `pend` and flush logic.

## Test plan
- `DATA_I_W`=1, `DATA_O_W`=16, sink ready, 16 beats of `1010_0000_1111_0011` MSB-first → `deser_data_o`=`16'hA0F3`, `deser_cnt_o`=16, valid exactly one cycle after the 16th beat.
- `DATA_I_W`=4, `DATA_O_W`=16, continuous beats `1,2,3,4,5,6,7,8` → words `16'h1234` then `16'h5678` on consecutive word slots; `data_rdy_o` never drops.
- Sink stalled, 48 one-bit beats offered → first word held stable, second word pending, `data_rdy_o`=0 after the 32nd beat. Release the sink → both words delivered in order, then the third.
- Flush build, `DATA_I_W`=4: beats `A`, `B` with `last` on `B` → `deser_data_o`=`16'hAB00`, `deser_cnt_o`=2. The next beat starts in the MSBs.
- Non-flush build: same stimulus → `last` ignored; the word completes after 4 beats with count 4.
- Reset asserted after 7 of 16 beats → no output. After release, 16 new beats produce exactly one correct word. All outputs are 0 during reset.
